// File: rtl/serial_tx_scheduler_pkg.sv
// Shared definitions for the serial transmit scheduler: FSM state encoding and requester ids.
package serial_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_tx_scheduler_piso.sv
// WIDTH-bit parallel-in/serial-out register, MSB first; load has priority over shift.
module piso_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign sout = sreg[WIDTH-1];

endmodule

// File: rtl/serial_tx_scheduler.sv
// Two-requester round-robin scheduler feeding one PISO lane; owns load/shift/gap sequencing.
module serial_tx_scheduler
    import serial_tx_scheduler_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             grant_id,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       gap_cnt;
    logic             rr_ptr;
    logic             winner;
    logic             can_accept;
    logic             xfer;
    logic             sout;
    logic [WIDTH-1:0] load_word;

    // With no gap, the last shift cycle may also accept so frames abut.
    always_comb begin
        can_accept = 1'b0;
        if (!reset) begin
            can_accept = (state == ST_IDLE) ||
                         ((GAP_CYCLES == 0) && (state == ST_SHIFT) && (cnt == CNT_LAST));
        end

        winner = REQ0;
        if (req0_valid && req1_valid) begin
            winner = rr_ptr;
        end else if (req1_valid) begin
            winner = REQ1;
        end

        req0_ready = can_accept && req0_valid && (winner == REQ0);
        req1_ready = can_accept && req1_valid && (winner == REQ1);
        xfer       = req0_ready || req1_ready;
        load_word  = (winner == REQ1) ? req1_data : req0_data;
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clock(clock),
        .reset(reset),
        .load (xfer),
        .shift(state == ST_SHIFT),
        .din  (load_word),
        .sout (sout)
    );

    assign ser_out = sout & ser_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            gap_cnt     <= '0;
            rr_ptr      <= REQ0;
            grant_id    <= REQ0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            if (xfer) begin
                state       <= ST_SHIFT;
                cnt         <= '0;
                grant_id    <= winner;
                rr_ptr      <= ~winner;
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
                frame_last  <= (CNT_LAST == '0);
                busy        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (cnt == CNT_LAST) begin
                            ser_valid <= 1'b0;
                            cnt       <= '0;
                            if (GAP_CYCLES > 0) begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt        <= cnt + 1'b1;
                            frame_last <= ((cnt + 1'b1) == CNT_LAST);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench: drivers push expected serial bits, monitors pop and compare each valid bit.
module tb_serial_tx_scheduler;

    typedef struct packed {
        logic b;
        logic s;
        logic l;
        logic g;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Instance A: one gap cycle
    logic        rst_a = 1'b1, v0_a = 1'b0, v1_a = 1'b0;
    logic [15:0] d0_a = '0, d1_a = '0;
    logic        r0_a, r1_a, so_a, sv_a, fs_a, fl_a, gid_a, busy_a;

    // Instance B: back-to-back
    logic        rst_b = 1'b1, v0_b = 1'b0, v1_b = 1'b0;
    logic [15:0] d0_b = '0, d1_b = '0;
    logic        r0_b, r1_b, so_b, sv_b, fs_b, fl_b, gid_b, busy_b;

    serial_tx_scheduler #(.WIDTH(16), .GAP_CYCLES(1)) dut_a (
        .clock(clk), .reset(rst_a),
        .req0_valid(v0_a), .req0_data(d0_a), .req0_ready(r0_a),
        .req1_valid(v1_a), .req1_data(d1_a), .req1_ready(r1_a),
        .ser_out(so_a), .ser_valid(sv_a), .frame_start(fs_a), .frame_last(fl_a),
        .grant_id(gid_a), .busy(busy_a)
    );

    serial_tx_scheduler #(.WIDTH(16), .GAP_CYCLES(0)) dut_b (
        .clock(clk), .reset(rst_b),
        .req0_valid(v0_b), .req0_data(d0_b), .req0_ready(r0_b),
        .req1_valid(v1_b), .req1_data(d1_b), .req1_ready(r1_b),
        .ser_out(so_b), .ser_valid(sv_b), .frame_start(fs_b), .frame_last(fl_b),
        .grant_id(gid_b), .busy(busy_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   fs_cyc_b[$];
    logic mon_on  = 1'b0;
    logic gap_chk = 1'b0;
    logic seen_a  = 1'b0;
    int   low_a   = 0;
    int   run_b   = 0;
    int   max_run_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic g, input logic [15:0] w, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.b = w[15-i]; e.s = (i == 0); e.l = (i == 15); e.g = g;
            q_a.push_back(e);
        end
    endtask

    task automatic push_b(input logic g, input logic [15:0] w);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.b = w[15-i]; e.s = (i == 0); e.l = (i == 15); e.g = g;
            q_b.push_back(e);
        end
    endtask

    // Returns at the negedge where a ready is seen; the following posedge is the transfer.
    task automatic wait_grant_a(output logic g, output int n, output logic ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r0_a || r1_a) && n < 200);
        ok = r0_a || r1_a;
        g  = r1_a;
        if (!ok) check("grant_timeout_a", 32'd0, 32'd1);
        else     check("one_ready_a", r0_a & r1_a, 1'b0);
    endtask

    task automatic wait_grant_b(output int n, output logic ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r0_b || r1_b) && n < 200);
        ok = r0_b || r1_b;
        if (!ok) check("grant_timeout_b", 32'd0, 32'd1);
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while ((q_a.size() != 0 || busy_a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, (q_a.size() == 0) && !busy_a, 1'b1);
    endtask

    task automatic reset_a();
        rst_a = 1'b1; v0_a = 1'b0; v1_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        check("reset_state_a", {sv_a, so_a, fs_a, fl_a, gid_a, busy_a, r0_a, r1_a}, 8'h00);
        check("reset_queue_a", q_a.size(), 0);
        q_a.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor A
    initial begin
        exp_t e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (sv_a === 1'b1) begin
                if (fs_a && seen_a && gap_chk) check("gap_len_a", low_a, 2);
                if (fs_a) seen_a = 1'b1;
                low_a = 0;
                if (q_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bit_a: got unexpected frame bit %b, expected no frame (t=%0t)", so_a, $time);
                end else begin
                    e = q_a.pop_front();
                    check("bit_a", {so_a, fs_a, fl_a, gid_a}, e);
                end
            end else begin
                low_a++;
                check("idle_out_a", {so_a, fs_a, fl_a}, 3'b000);
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (sv_b === 1'b1) begin
                run_b++;
                if (fs_b) fs_cyc_b.push_back(cyc);
                if (q_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bit_b: got unexpected frame bit %b, expected no frame (t=%0t)", so_b, $time);
                end else begin
                    e = q_b.pop_front();
                    check("bit_b", {so_b, fs_b, fl_b, gid_b}, e);
                end
            end else begin
                if (run_b > max_run_b) max_run_b = run_b;
                run_b = 0;
                check("idle_out_b", {so_b, fs_b, fl_b}, 3'b000);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g, ok;
        int          n, c0, i0, i1;
        logic [15:0] w0 [2];
        logic [15:0] w1 [2];
        logic        order2 [4];
        logic        order6 [4];

        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;

        // Test 1: single req0 frame, ready pulses once, re-arms after frame + gap + idle
        reset_a();
        v0_a = 1'b1; d0_a = 16'hA5C3;
        wait_grant_a(g, n, ok);
        check("t1_grant", g, 1'b0);
        push_a(1'b0, 16'hA5C3, 16);
        @(posedge clk); #1 d0_a = 16'h3C5A;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("t1_ready_low", r0_a, 1'b0);
        end
        wait_grant_a(g, n, ok);
        check("t1_rearm_delay", n, 1);
        push_a(1'b0, 16'h3C5A, 16);
        @(posedge clk); #1 v0_a = 1'b0;
        drain_a("t1_drain");

        // Test 2: both valid, grants alternate, two low cycles between frames
        reset_a();
        w0[0] = 16'h1234; w0[1] = 16'h9ABC;
        w1[0] = 16'h5678; w1[1] = 16'hDEF0;
        order2[0] = 1'b0; order2[1] = 1'b1; order2[2] = 1'b0; order2[3] = 1'b1;
        i0 = 0; i1 = 0;
        seen_a = 1'b0; gap_chk = 1'b1;
        v0_a = 1'b1; d0_a = w0[0]; v1_a = 1'b1; d1_a = w1[0];
        for (int k = 0; k < 4; k++) begin
            wait_grant_a(g, n, ok);
            if (!ok) break;
            check("t2_grant", g, order2[k]);
            push_a(g, g ? d1_a : d0_a, 16);
            @(posedge clk); #1;
            if (g == 1'b0) begin
                i0++;
                if (i0 < 2) d0_a = w0[i0]; else v0_a = 1'b0;
            end else begin
                i1++;
                if (i1 < 2) d1_a = w1[i1]; else v1_a = 1'b0;
            end
        end
        drain_a("t2_drain");
        gap_chk = 1'b0;

        // Test 3: back-to-back frames on the no-gap instance
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        v1_b = 1'b1; d1_b = 16'hFFFF;
        wait_grant_b(n, ok);
        c0 = cyc;
        check("t3_first_ready", r1_b, 1'b1);
        push_b(1'b1, 16'hFFFF);
        @(posedge clk); #1 d1_b = 16'h0001;
        wait_grant_b(n, ok);
        check("t3_ready_on_last", {r1_b, fl_b, sv_b}, 3'b111);
        push_b(1'b1, 16'h0001);
        @(posedge clk); #1 v1_b = 1'b0;
        n = 0;
        while ((q_b.size() != 0 || busy_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t3_drain", q_b.size(), 0);
        check("t3_run_len", max_run_b, 32);
        check("t3_starts", fs_cyc_b.size(), 2);
        if (fs_cyc_b.size() == 2) begin
            check("t3_start1", fs_cyc_b[0] - c0, 1);
            check("t3_start2", fs_cyc_b[1] - c0, 17);
        end

        // Test 4: reset at counter==7 aborts; pointer returns to req0
        reset_a();
        v0_a = 1'b1; d0_a = 16'h8001;
        wait_grant_a(g, n, ok);
        push_a(1'b0, 16'h8001, 8);
        @(posedge clk); #1 v0_a = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        check("t4_abort", {sv_a, busy_a, so_a}, 3'b000);
        check("t4_queue", q_a.size(), 0);
        @(posedge clk); #1;
        v0_a = 1'b1; d0_a = 16'h0F0F; v1_a = 1'b1; d1_a = 16'hF0F0;
        wait_grant_a(g, n, ok);
        check("t4_ptr_reset", g, 1'b0);
        push_a(1'b0, 16'h0F0F, 16);
        @(posedge clk); #1 v0_a = 1'b0;
        wait_grant_a(g, n, ok);
        check("t4_next", g, 1'b1);
        push_a(1'b1, 16'hF0F0, 16);
        @(posedge clk); #1 v1_a = 1'b0;
        drain_a("t4_drain");

        // Test 5: idle with no valids
        reset_a();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t5_idle", {busy_a, r0_a, r1_a, sv_a}, 4'b0000);
        end

        // Test 6: lone req1 wins even with pointer at req0; then pointer still req0
        reset_a();
        order6[0] = 1'b1; order6[1] = 1'b1; order6[2] = 1'b0; order6[3] = 1'b1;
        v1_a = 1'b1; d1_a = 16'h1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant_a(g, n, ok);
            if (!ok) break;
            check("t6_grant", g, order6[k]);
            push_a(g, g ? d1_a : d0_a, 16);
            @(posedge clk); #1;
            case (k)
                0: d1_a = 16'h2222;
                1: begin v0_a = 1'b1; d0_a = 16'h3333; d1_a = 16'h4444; end
                2: v0_a = 1'b0;
                default: v1_a = 1'b0;
            endcase
        end
        drain_a("t6_drain");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
